// File: rtl/fun_dec_pkg.sv
// fun_dec_pkg: shared state encodings and constants for fun_decoder_seq
package fun_dec_pkg;
  localparam int CNT_W = 8;
  localparam logic [7:0] DROP_MAX = 8'd255;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2} state_e;
endpackage

// File: rtl/fun_dec_skid.sv
// fun_dec_skid: one-entry holding register for a code that arrives while the decoder is busy
module fun_dec_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_i,
  input  logic       dr_i,
  input  logic [2:0] d_i,
  output logic       full_o,
  output logic [2:0] q_o
);
  logic       full_q;
  logic [2:0] code_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      code_q <= '0;
    end else begin
      full_q <= ld_i || (full_q && !dr_i);
      if (ld_i) code_q <= d_i;
    end
  end
  assign full_o = full_q;
  assign q_o    = code_q;
endmodule

// File: rtl/fun_decoder_seq.sv
// fun_decoder_seq: registered 3-to-8 decoder with dwell/gap timing and drop counting.
// Define FUN_DECODER_SKID_EN to add a one-entry skid buffer in front of the FSM.
module fun_decoder_seq #(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] D,
  input  logic       val,
  output logic       rdy,
  output logic [7:0] O,
  output logic       busy,
  output logic       drop,
  output logic [7:0] drop_cnt
);
  import fun_dec_pkg::*;
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP > 0 ? GAP - 1 : 0);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       o_q, o_d, drop_cnt_q, drop_cnt_d;
  logic             drop_q, drop_d, idle, fin, acc, nxt;
  logic [2:0]       nxt_code;
  assign idle = state_q == IDLE;
  // fin: this edge would otherwise return the FSM to IDLE
  assign fin  = cnt_q == '0 && (state_q == fun_dec_pkg::GAP || (state_q == DRIVE && GAP == 0));
  assign acc  = val && rdy;
`ifdef FUN_DECODER_SKID_EN
  logic       skid_full, skid_ld, skid_dr;
  logic [2:0] skid_code;
  assign rdy      = idle || !skid_full;
  assign skid_dr  = fin && skid_full;
  // a code accepted on the finishing edge with an empty skid starts DRIVE directly
  assign skid_ld  = acc && !idle && !(fin && !skid_full);
  assign nxt      = idle ? acc : fin && (skid_full || acc);
  assign nxt_code = skid_full ? skid_code : D;
  fun_dec_skid u_skid (
    .clk    (clk),
    .rst    (rst),
    .ld_i   (skid_ld),
    .dr_i   (skid_dr),
    .d_i    (D),
    .full_o (skid_full),
    .q_o    (skid_code)
  );
`else
  assign rdy      = idle;
  assign nxt      = acc;
  assign nxt_code = D;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    if (nxt) begin
      state_d = DRIVE;
      cnt_d   = DWELL_LD;
      o_d     = 8'b1 << nxt_code;
    end else if (fin) begin
      state_d = IDLE;
      o_d     = '0;
    end else if (state_q == DRIVE && cnt_q == '0) begin
      state_d = fun_dec_pkg::GAP;
      cnt_d   = GAP_LD;
      o_d     = '0;
    end else if (!idle) begin
      cnt_d   = cnt_q - 1'b1;
    end
  end
  assign drop_d     = val && !rdy;
  assign drop_cnt_d = (drop_d && drop_cnt_q != DROP_MAX) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      o_q        <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_q        <= o_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign O        = o_q;
  assign busy     = !idle;
  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_fun_decoder_seq.sv
// tb_fun_decoder_seq: scoreboard bench for fun_decoder_seq (DWELL=4/GAP=1 and DWELL=1/GAP=0 instances)
module tb_fun_decoder_seq;
  localparam int DW = 4;
  localparam int GP = 1;
`ifdef FUN_DECODER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst, val, val_e;
  logic [2:0] D, D_e;
  logic       rdy, busy, drop, rdy_e, busy_e, drop_e;
  logic [7:0] O, drop_cnt, O_e, drop_cnt_e;
  int         checks = 0, failures = 0, drop_seen = 0, multi = 0;
  bit         sb_on = 1'b0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  fun_decoder_seq #(.DWELL(DW), .GAP(GP)) u_dut (
    .clk(clk), .rst(rst), .D(D), .val(val), .rdy(rdy), .O(O),
    .busy(busy), .drop(drop), .drop_cnt(drop_cnt)
  );
  fun_decoder_seq #(.DWELL(1), .GAP(0)) u_edge (
    .clk(clk), .rst(rst), .D(D_e), .val(val_e), .rdy(rdy_e), .O(O_e),
    .busy(busy_e), .drop(drop_e), .drop_cnt(drop_cnt_e)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic push_code(input logic [2:0] d);
    logic [7:0] oh;
    oh = 8'h01 << d;
    for (int i = 0; i < DW; i++) exp_q.push_back(oh);
    for (int i = 0; i < GP; i++) exp_q.push_back(8'h00);
  endtask
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (drop) drop_seen++;
    if ($countones(O) > 1 || $countones(O_e) > 1) multi++;
    if (sb_on) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
      chk("O_sb", {24'd0, O}, {24'd0, e});
    end
  endtask
  initial begin
    rst = 1'b1; val = 1'b0; val_e = 1'b0; D = '0; D_e = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_O", O, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_drop", drop, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_O_edge", O_e, 0);
    chk("rst_rdy_edge", rdy_e, 1);
    // sweep all codes at the minimum spacing
    sb_on = 1'b1;
    drop_seen = 0;
    for (int k = 0; k < 8; k++) begin
      chk("sweep_rdy", rdy, 1);
      val = 1'b1; D = 3'(k);
      push_code(3'(k));
      step();
      val = 1'b0;
      chk("sweep_busy", busy, 1);
      repeat (5) step();
    end
    chk("sweep_drops", drop_seen, 0);
    chk("sweep_drop_cnt", drop_cnt, 0);
    chk("sweep_q_empty", exp_q.size(), 0);
    // second code two cycles after the first
    drop_seen = 0;
    val = 1'b1; D = 3'd5;
    push_code(3'd5);
    step();
    val = 1'b0;
    step();
    chk("bp_rdy", rdy, SKID ? 1 : 0);
    val = 1'b1; D = 3'd2;
    if (SKID) push_code(3'd2);
    step();
    val = 1'b0;
    repeat (12) step();
    chk("bp_drop_pulses", drop_seen, SKID ? 0 : 1);
    chk("bp_drop_cnt", drop_cnt, SKID ? 0 : 1);
    chk("bp_q_empty", exp_q.size(), 0);
    // saturation: val every cycle
    sb_on = 1'b0;
    multi = 0;
    val = 1'b1;
    repeat (600) begin
      D = 3'($urandom_range(0, 7));
      step();
    end
    val = 1'b0;
    chk("sat_drop_cnt", drop_cnt, 255);
    repeat (2) step();
    chk("sat_hold", drop_cnt, 255);
    chk("sat_onehot", multi, 0);
    repeat (8) step();
    chk("sat_idle_busy", busy, 0);
    // reset during the second DRIVE cycle
    val = 1'b1; D = 3'd7;
    step();
    val = 1'b0;
    chk("mid_O1", O, 8'h80);
    step();
    chk("mid_O2", O, 8'h80);
    rst = 1'b1; val = 1'b1; D = 3'd1;
    step();
    rst = 1'b0; val = 1'b0;
    chk("mid_rst_O", O, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", rdy, 1);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    step();
    chk("mid_after_O", O, 0);
    chk("mid_after_drop_cnt", drop_cnt, 0);
    // DWELL=1, GAP=0 with val held high
    multi = 0;
    val_e = 1'b1; D_e = 3'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("edge_O", O_e, (SKID || i % 2 == 0) ? 8'h08 : 8'h00);
      chk("edge_drop", drop_e, (!SKID && i % 2 == 1) ? 1 : 0);
    end
    val_e = 1'b0;
    step();
    chk("edge_drop_cnt", drop_cnt_e, SKID ? 0 : 5);
    chk("edge_onehot", multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
